// File: rtl/systolic_feeder_pkg.sv
// Shared types and default sizing for the systolic array operand feeder.
package feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_FLUSH,
    ST_PUSH,
    ST_DONE
  } feeder_state_t;

  localparam int DEF_TILE   = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 17;

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand beat stream into the feeder: one A column slice and one B row slice per beat.
// A beat transfers on a rising clk edge where in_valid && in_ready; the master holds
// in_valid/in_a/in_b stable until that edge, and in_ready never depends on in_valid.
interface systolic_feeder_if #(
  parameter int TILE   = 2,
  parameter int DATA_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [TILE*DATA_W-1:0] in_a;
  logic [TILE*DATA_W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// One lane of operand skew: a DEPTH-stage shift register advancing only on en,
// loading zeros instead of d while zero_in is high (array drain).
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (en) begin
      r_sr[0] <= zero_in ? '0 : d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign q = r_sr[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed A/B operands into a TILE x TILE systolic array and sequences clear/flush/unload per tile.
// Optional stall counter enabled by defining SYSTOLIC_FEEDER_STALL_CNT_EN.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int TILE   = DEF_TILE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         k_len,
  input  logic [LEN_W-1:0]         n_tiles,
  systolic_feeder_if.slave         s_in,
  output logic [TILE*DATA_W-1:0]   a_out,
  output logic [TILE*DATA_W-1:0]   b_out,
  output logic                     feed_en,
  output logic                     acc_clr,
  output logic                     push,
  output logic [$clog2(TILE)-1:0]  push_row,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              stall_cnt,
  output feeder_state_t            dbg_state
);
  localparam int FLUSH_LEN = 2*TILE - 2;
  localparam int FL_W      = $clog2(2*TILE);
  localparam int ROW_W     = $clog2(TILE);

  feeder_state_t      r_state, w_next;
  logic [LEN_W-1:0]   r_k_len, r_n_tiles, r_beat;
  logic [FL_W-1:0]    r_flush;
  logic [ROW_W-1:0]   r_row;
  logic [2*LEN_W-1:0] r_tile, w_tile_inc;
  logic               w_accept, w_last_beat, w_flush_last, w_row_last, w_more, w_flush;

  assign w_accept     = (r_state == ST_RUN) && s_in.in_valid;
  assign w_last_beat  = (r_beat == r_k_len - LEN_W'(1));
  assign w_flush_last = (r_flush == FL_W'(FLUSH_LEN - 1));
  assign w_row_last   = (r_row == ROW_W'(TILE - 1));
  assign w_tile_inc   = r_tile + (2*LEN_W)'(1);
  assign w_more       = (w_tile_inc < (2*LEN_W)'(r_n_tiles));
  assign w_flush      = (r_state == ST_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (k_len != '0 && n_tiles != '0) ? ST_CLR : ST_DONE;
      ST_CLR:   w_next = ST_RUN;
      ST_RUN:   if (w_accept && w_last_beat) w_next = ST_FLUSH;
      ST_FLUSH: if (w_flush_last) w_next = ST_PUSH;
      ST_PUSH:  if (w_row_last) w_next = w_more ? ST_CLR : ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign s_in.in_ready = (r_state == ST_RUN);
  assign feed_en       = w_accept || w_flush;
  assign acc_clr       = (r_state == ST_CLR);
  assign push          = (r_state == ST_PUSH);
  assign push_row      = r_row;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign dbg_state     = r_state;

  // Job parameters are latched at launch so the host may change them mid-job.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k_len   <= '0;
      r_n_tiles <= '0;
      r_beat    <= '0;
      r_flush   <= '0;
      r_row     <= '0;
      r_tile    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_k_len   <= k_len;
          r_n_tiles <= n_tiles;
          r_tile    <= '0;
        end
        ST_CLR: begin
          r_beat  <= '0;
          r_flush <= '0;
          r_row   <= '0;
        end
        ST_RUN:   if (w_accept) r_beat <= r_beat + LEN_W'(1);
        ST_FLUSH: r_flush <= r_flush + FL_W'(1);
        ST_PUSH: begin
          r_row <= r_row + ROW_W'(1);
          if (w_row_last) r_tile <= w_tile_inc;
        end
        default: ;
      endcase
    end
  end

  // Lane i needs i extra stages so the array sees the classic diagonal wavefront.
  for (genvar i = 0; i < TILE; i++) begin : g_lane
    skew_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_skew_a (
      .clk(clk), .reset(reset), .en(feed_en), .zero_in(w_flush),
      .d(s_in.in_a[i*DATA_W +: DATA_W]), .q(a_out[i*DATA_W +: DATA_W])
    );
    skew_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_skew_b (
      .clk(clk), .reset(reset), .en(feed_en), .zero_in(w_flush),
      .d(s_in.in_b[i*DATA_W +: DATA_W]), .q(b_out[i*DATA_W +: DATA_W])
    );
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk) begin
    if (reset)
      r_stall <= '0;
    else if (r_state == ST_CLR && r_tile == '0)
      r_stall <= '0;
    else if (r_state == ST_RUN && !s_in.in_valid && r_stall != 32'hFFFF_FFFF)
      r_stall <= r_stall + 32'd1;
  end
  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter TILE, default 2: array edge length (2..8); output tile is TILE x TILE.
REQ-002 Parameter DATA_W, default 8: signed operand width.
REQ-003 Parameter LEN_W, default 17: width of k_len and n_tiles.
REQ-004 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  launch job; sampled in IDLE only.
REQ-007 k_len  input  LEN_W  inner dimension (beats per tile), captured on start.
REQ-008 n_tiles  input  LEN_W  output tiles in job, captured on start.
REQ-009 in_valid / in_ready  input / output  1  operand beat handshake.
REQ-010 in_a  input  TILE*DATA_W  A column slice; lane i = rows i.
REQ-011 in_b  input  TILE*DATA_W  B row slice; lane j = column j.
REQ-012 a_out / b_out  output  TILE*DATA_W  skewed operands to array edges.
REQ-013 feed_en  output  1  array advance strobe.
REQ-014 acc_clr  output  1  one-cycle clear of array accumulators.
REQ-015 push  output  1  unload strobe; push_row  output  $clog2(TILE)  row being unloaded.
REQ-016 busy / done  output  1  job active / one-cycle job-complete pulse.
REQ-017 stall_cnt  output  32  RUN cycles with in_valid low.

Function
REQ-018 States: IDLE, CLR, RUN, FLUSH, PUSH, DONE.
REQ-019 IDLE->CLR on start with k_len>0 and n_tiles>0; IDLE->DONE on start with either zero (no beats consumed).
REQ-020 CLR: one cycle, acc_clr=1, tile beat counter zeroed, ->RUN.
REQ-021 RUN: in_ready=1; beat accepted when in_valid&in_ready; each accepted beat shifts skew lines and asserts feed_en same cycle.
REQ-022 RUN with in_valid low: skew lines hold, feed_en=0 (stall, no bubble inserted).
REQ-023 RUN->FLUSH on the cycle the k_len-th beat is accepted.
REQ-024 FLUSH: exactly 2*TILE-2 cycles, skew lines shift zeros in, feed_en=1, in_ready=0, ->PUSH.
REQ-025 PUSH: TILE cycles, push=1, push_row counts 0..TILE-1.
REQ-026 After PUSH: tile count < n_tiles ->CLR, else ->DONE.
REQ-027 DONE: one cycle, done=1, ->IDLE.
REQ-028 Skew: lane i of a_out is in_a lane i delayed i feed_en-advances; same for b_out lane j; lane 0 registered once (latency 1).
REQ-029 busy=1 in every state but IDLE; start while busy ignored.
REQ-030 Tile counter LEN_W*2 bits; no wrap for max n_tiles.

Reset
REQ-031 Reset: state IDLE; all skew registers, counters, stall_cnt zero; in_ready, feed_en, acc_clr, push, push_row, busy, done = 0.
REQ-032 Reset mid-job aborts immediately; no done pulse; next job starts clean.

Configuration
REQ-033 Macro SYSTOLIC_FEEDER_STALL_CNT_EN defined: stall_cnt increments per RUN cycle with in_valid=0, saturates at 2^32-1, clears on CLR of first tile.
REQ-034 Macro undefined: stall_cnt tied to 0, no counter logic.

Structure
REQ-035 Package feeder_pkg holds state enum feeder_state_t and default TILE/DATA_W/LEN_W constants.
REQ-036 Sub-module skew_line (parameters DEPTH, DATA_W; enable; zero-insert input) instantiated once per lane per operand.

Verification
REQ-037 TILE=2, k_len=4, n_tiles=1, in_valid stuck 1 -> 4 beats accepted, 2 FLUSH cycles, push rows 0,1, done at cycle 1(CLR)+4+2+2+1.
REQ-038 TILE=4, in_a lanes {1,2,3,4} single beat -> a_out lane 3 shows 4 exactly 4 feed_en-advances later.
REQ-039 k_len=3, in_valid toggling 1,0,1,0,1 -> feed_en only on accepted beats; stall_cnt=2 with macro, 0 without.
REQ-040 n_tiles=3 -> acc_clr pulses 3 times, push bursts 3, single done.
REQ-041 k_len=0 -> done one cycle after start, in_ready never 1.
REQ-042 reset asserted mid-FLUSH -> all outputs 0 next cycle, no done; new start completes normally.
